// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// valid/ready handshakes on input and output.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               value,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*DIGITS-1:0]            bcd,
    output logic [$clog2(DIGITS+1)-1:0]    num_digits
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int NUM_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    bin_sr;
    logic [BCD_W-1:0]    bcd_acc;
    logic [CNT_W-1:0]    count;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;

    // Digits >= 5 get +3 independently so the following doubling carries correctly.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_W-1:0] digit_count(input logic [BCD_W-1:0] acc);
        logic [NUM_W-1:0] n;
        n = NUM_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] != 4'd0) begin
                n = NUM_W'(i + 1);
            end
        end
        return n;
    endfunction

    always_comb begin
        bcd_adj   = add3_digits(bcd_acc);
        bcd_shift = (bcd_adj << 1) | BCD_W'(bin_sr[WIDTH-1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            bcd        <= '0;
            num_digits <= '0;
            count      <= '0;
            bin_sr     <= '0;
            bcd_acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr   <= value;
                        bcd_acc  <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_acc <= bcd_shift;
                    bin_sr  <= bin_sr << 1;
                    count   <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        bcd        <= bcd_shift;
                        num_digits <= digit_count(bcd_shift);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Result stays registered; in_ready rises only after handoff.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected BCD pushed on drive, popped on result.
module tb_bin_to_bcd_seq;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] bcd;
    logic [3:0]  num_digits;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [39:0] bcd;
        logic [3:0]  nd;
    } exp_t;

    exp_t sb_q[$];

    bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .value      (value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bcd        (bcd),
        .num_digits (num_digits)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [39:0] bcd_ref(input logic [31:0] v);
        logic [39:0] r;
        longint      x;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] nd_ref(input logic [31:0] v);
        longint x;
        int     n;
        x = longint'(v);
        n = 1;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return 4'(n);
    endfunction

    function automatic logic digits_ok(input logic [39:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Drive one value, wait for the result, optionally stall the consumer.
    task automatic convert(input logic [31:0] v, input int hold, input bit keep_valid);
        exp_t        e;
        int          n;
        int          lat;
        logic [39:0] held_bcd;
        logic [3:0]  held_nd;
        sb_q.push_back('{bcd: bcd_ref(v), nd: nd_ref(v)});
        in_valid  = 1'b1;
        value     = v;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        step();
        if (!keep_valid) in_valid = 1'b0;
        value = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (lat == 5) chk("shift_in_ready", 64'(in_ready), 64'd0);
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'd32);
        chk("done_in_ready", 64'(in_ready), 64'd0);
        e = sb_q.pop_front();
        chk("bcd", 64'(bcd), 64'(e.bcd));
        chk("num_digits", 64'(num_digits), 64'(e.nd));
        chk("digit_range", 64'(digits_ok(bcd)), 64'd1);
        held_bcd = bcd;
        held_nd  = num_digits;
        if (hold > 0) in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            in_valid = 1'b0;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_bcd", 64'(bcd), 64'(held_bcd));
            chk("hold_nd", 64'(num_digits), 64'(held_nd));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("handoff_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        chk("handoff_bcd_kept", 64'(bcd), 64'(held_bcd));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        value     = '0;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_nd", 64'(num_digits), 64'd0);
        reset_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("idle_no_valid", 64'(out_valid), 64'd0);

        convert(32'd0, 0, 1'b0);
        convert(32'hFFFF_FFFF, 0, 1'b0);
        chk("max_bcd_const", 64'(bcd), 64'h42_9496_7295);
        convert(32'd1234567890, 0, 1'b1);
        convert(32'd7, 0, 1'b0);
        convert(32'd100, 5, 1'b0);
        chk("hundred_nd_const", 64'(num_digits), 64'd3);

        // Abort a conversion mid-way with an asynchronous reset.
        in_valid = 1'b1;
        value    = 32'd999999;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_busy", 64'(in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_bcd", 64'(bcd), 64'd0);
        chk("async_nd", 64'(num_digits), 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        convert(32'd45, 0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd1;
            convert(a / b, 0, 1'b0);
            convert(a % b, 0, 1'b0);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
